// File: rtl/lcd_pkg.sv
// Shared types for the LCD host agent: command codes, host FSM states, image size.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

    localparam int IMG_SIZE = 64;
    localparam int IMG_AW   = 6;

    // Controller command codes; 4'hC..4'hF are unused and ignored by the controller
    typedef enum logic [3:0] {
        CMD_WRITE       = 4'h0,
        CMD_SHIFT_UP    = 4'h1,
        CMD_SHIFT_DOWN  = 4'h2,
        CMD_SHIFT_LEFT  = 4'h3,
        CMD_SHIFT_RIGHT = 4'h4,
        CMD_MAX         = 4'h5,
        CMD_MIN         = 4'h6,
        CMD_AVERAGE     = 4'h7,
        CMD_ROT_CCW     = 4'h8,
        CMD_ROT_CW      = 4'h9,
        CMD_MIRROR_X    = 4'hA,
        CMD_MIRROR_Y    = 4'hB
    } lcd_cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_LOAD = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_FINISHED  = 2'd3
    } host_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of WIDTH bits, show-ahead read data.
// Latency: pushed entry visible on pop_data one cycle after the push edge.
// Backpressure: full blocks push unless a pop happens in the same cycle; pop on empty is ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Pointer update; a pop frees a slot for a same-cycle push on a full queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lcd_host_agent.sv
// Host-side agent for the LCD controller: image ROM, queued command issue, result capture.
// Latency: IROM_Q/res_data combinational; cmd one cycle after pop decision; res_ready one cycle after done.
// Backpressure: hcmd_ready low when queue full or sealed by WRITE; controller busy stalls command issue.
// Build option: define LCD_HOST_CKSUM_EN to build the capture checksum (otherwise cksum reads 0).
module lcd_host_agent
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CKSUM_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               img_we,
    input  logic [5:0]         img_addr,
    input  logic [7:0]         img_wdata,
    input  logic [3:0]         hcmd,
    input  logic               hcmd_valid,
    output logic               hcmd_ready,
    input  logic               IROM_rd,
    input  logic [5:0]         IROM_A,
    output logic [7:0]         IROM_Q,
    output logic [3:0]         cmd,
    output logic               cmd_valid,
    input  logic               busy,
    input  logic               IRAM_valid,
    input  logic [6:0]         IRAM_A,
    input  logic [7:0]         IRAM_D,
    input  logic               done,
    input  logic [5:0]         res_addr,
    output logic [7:0]         res_data,
    output logic               res_ready,
    output logic [6:0]         wr_count,
    output logic [CKSUM_W-1:0] cksum
);

    logic [7:0]  img_mem [IMG_SIZE];
    logic [7:0]  res_mem [IMG_SIZE];

    host_state_e state;
    logic        busy_seen;
    logic        sealed;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_dout;
    logic        unused_iram_a_msb;

    // Only the low six address bits select a result byte
    assign unused_iram_a_msb = IRAM_A[6];

    assign IROM_Q     = IROM_rd ? img_mem[IROM_A] : 8'h00;
    assign res_data   = res_mem[res_addr];
    assign fifo_pop   = (state == ST_ISSUE) && !busy && !fifo_empty;
    assign hcmd_ready = !sealed && (!fifo_full || fifo_pop);
    assign fifo_push  = hcmd_valid && hcmd_ready;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (hcmd),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Image store written by the host at any time
    always_ff @(posedge clk) begin
        if (img_we) img_mem[img_addr] <= img_wdata;
    end

    // Result store written by the controller stream in any state
    always_ff @(posedge clk) begin
        if (IRAM_valid) res_mem[IRAM_A[5:0]] <= IRAM_D;
    end

    // Queue seals after WRITE is accepted; nothing can follow the final command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sealed <= 1'b0;
        end else if (fifo_push && (hcmd == CMD_WRITE)) begin
            sealed <= 1'b1;
        end
    end

    // Host FSM: wait for the image load pulse on busy, issue commands, drain until done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_WAIT_LOAD;
            busy_seen <= 1'b0;
            cmd       <= 4'h0;
            cmd_valid <= 1'b0;
            res_ready <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                ST_WAIT_LOAD: begin
                    if (busy)           busy_seen <= 1'b1;
                    else if (busy_seen) state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (fifo_pop) begin
                        cmd       <= fifo_dout;
                        cmd_valid <= 1'b1;
                        if (fifo_dout == CMD_WRITE) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        res_ready <= 1'b1;
                        state     <= ST_FINISHED;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count of captured bytes, saturating at a full image
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= 7'd0;
        end else if (IRAM_valid && (wr_count != 7'(IMG_SIZE))) begin
            wr_count <= wr_count + 7'd1;
        end
    end

`ifdef LCD_HOST_CKSUM_EN
    // Running sum of every captured byte, wrapping at the checksum width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum <= '0;
        end else if (IRAM_valid) begin
            cksum <= cksum + CKSUM_W'(IRAM_D);
        end
    end
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_lcd_host_agent.sv
// Directed bench for lcd_host_agent: image reads, command issue, sealing, capture, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_host_agent;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_we;
    logic [5:0]  img_addr;
    logic [7:0]  img_wdata;
    logic [3:0]  hcmd;
    logic        hcmd_valid;
    logic        hcmd_ready;
    logic        IROM_rd;
    logic [5:0]  IROM_A;
    logic [7:0]  IROM_Q;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        IRAM_valid;
    logic [6:0]  IRAM_A;
    logic [7:0]  IRAM_D;
    logic        done;
    logic [5:0]  res_addr;
    logic [7:0]  res_data;
    logic        res_ready;
    logic [6:0]  wr_count;
    logic [15:0] cksum;

    int n_checks = 0;
    int n_errors = 0;

    lcd_host_agent #(.FIFO_DEPTH(4), .CKSUM_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_wdata  (img_wdata),
        .hcmd       (hcmd),
        .hcmd_valid (hcmd_valid),
        .hcmd_ready (hcmd_ready),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .done       (done),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .wr_count   (wr_count),
        .cksum      (cksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the first command strobe
    task automatic wait_cmd(input string tag);
        int n = 0;
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        check(tag, 32'(cmd_valid), 32'd1);
    endtask

    logic [3:0]  exp_q [4];
    logic [15:0] exp_ck;

    initial begin
        reset = 1'b1; img_we = 0; img_addr = 0; img_wdata = 0;
        hcmd = 0; hcmd_valid = 0; IROM_rd = 0; IROM_A = 0;
        busy = 0; IRAM_valid = 0; IRAM_A = 0; IRAM_D = 0; done = 0; res_addr = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_cksum", 32'(cksum), 32'd0);
        check("rst_hcmd_ready", 32'(hcmd_ready), 32'd1);
        check("rst_state", 32'(dut.state), 32'(ST_WAIT_LOAD));

        // done outside DRAIN must be ignored
        done = 1'b1; tick(); done = 1'b0; tick();
        check("done_ignored_ready", 32'(res_ready), 32'd0);
        check("done_ignored_state", 32'(dut.state), 32'(ST_WAIT_LOAD));

        // Image load and same-cycle reads
        for (int i = 0; i < 64; i++) begin
            img_we = 1'b1; img_addr = 6'(i); img_wdata = 8'(i);
            tick();
        end
        img_we = 1'b0;
        IROM_rd = 1'b1;
        for (int a = 0; a < 64; a++) begin
            IROM_A = 6'(a);
            #1;
            check($sformatf("irom_q[%0d]", a), 32'(IROM_Q), 32'(a));
        end
        IROM_rd = 1'b0; IROM_A = 6'd5;
        #1;
        check("irom_q_idle", 32'(IROM_Q), 32'h00);

        // Fill the queue while busy, then release busy
        exp_q[0] = 4'h1; exp_q[1] = 4'h5; exp_q[2] = 4'hC; exp_q[3] = 4'h3;
        busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hcmd = exp_q[k]; hcmd_valid = 1'b1;
            tick();
        end
        hcmd_valid = 1'b0;
        check("full_hcmd_ready", 32'(hcmd_ready), 32'd0);
        check("full_no_issue", 32'(cmd_valid), 32'd0);
        busy = 1'b0;
        wait_cmd("fill_first_cmd");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill_valid[%0d]", k), 32'(cmd_valid), 32'd1);
            check($sformatf("fill_cmd[%0d]", k), 32'(cmd), 32'(exp_q[k]));
            tick();
        end
        check("fill_after_valid", 32'(cmd_valid), 32'd0);
        check("fill_after_cmd_hold", 32'(cmd), 32'h3);
        check("fill_state_issue", 32'(dut.state), 32'(ST_ISSUE));

        // Push 1,5,0 under busy; WRITE seals the queue
        exp_q[0] = 4'h1; exp_q[1] = 4'h5; exp_q[2] = 4'h0;
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hcmd = exp_q[k]; hcmd_valid = 1'b1;
            tick();
        end
        check("sealed_hcmd_ready", 32'(hcmd_ready), 32'd0);
        hcmd = 4'h9;
        tick(); tick();
        check("busy_blocks_issue", 32'(cmd_valid), 32'd0);
        busy = 1'b0;
        wait_cmd("seal_first_cmd");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("seal_valid[%0d]", k), 32'(cmd_valid), 32'd1);
            check($sformatf("seal_cmd[%0d]", k), 32'(cmd), 32'(exp_q[k]));
            tick();
        end
        check("drain_state", 32'(dut.state), 32'(ST_DRAIN));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain_no_valid[%0d]", k), 32'(cmd_valid), 32'd0);
            tick();
        end
        check("drain_hcmd_ready", 32'(hcmd_ready), 32'd0);
        check("drain_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        hcmd_valid = 1'b0;

        // Result capture: D = A + 1
        for (int a = 0; a < 64; a++) begin
            IRAM_valid = 1'b1; IRAM_A = 7'(a); IRAM_D = 8'(a + 1);
            tick();
        end
        IRAM_valid = 1'b0;
`ifdef LCD_HOST_CKSUM_EN
        exp_ck = 16'd2080;
`else
        exp_ck = 16'd0;
`endif
        check("cap_wr_count", 32'(wr_count), 32'd64);
        check("cap_cksum", 32'(cksum), 32'(exp_ck));
        check("cap_not_ready", 32'(res_ready), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done_res_ready", 32'(res_ready), 32'd1);
        check("finished_state", 32'(dut.state), 32'(ST_FINISHED));

        // 65th write with address MSB set: saturates count, rewrites res[0] with same value
        IRAM_valid = 1'b1; IRAM_A = 7'h40; IRAM_D = 8'd1;
        tick();
        IRAM_valid = 1'b0;
`ifdef LCD_HOST_CKSUM_EN
        exp_ck = 16'd2081;
`endif
        check("sat_wr_count", 32'(wr_count), 32'd64);
        check("sat_cksum", 32'(cksum), 32'(exp_ck));
        tick();
        check("res_ready_sticky", 32'(res_ready), 32'd1);
        for (int a = 0; a < 64; a++) begin
            res_addr = 6'(a);
            #1;
            check($sformatf("res[%0d]", a), 32'(res_data), 32'(a + 1));
        end

        // Fresh run, reset asserted during ISSUE with two entries queued
        reset = 1'b1; tick(); reset = 1'b0;
        busy = 1'b1; tick(); busy = 1'b0; tick();
        check("rr_state_issue", 32'(dut.state), 32'(ST_ISSUE));
        busy = 1'b1;
        hcmd_valid = 1'b1; hcmd = 4'h2; tick();
        hcmd = 4'h3; tick();
        hcmd_valid = 1'b0;
        IRAM_valid = 1'b1; IRAM_A = 7'd0; IRAM_D = 8'd7; tick();
        IRAM_valid = 1'b0;
        check("rr_pre_wr_count", 32'(wr_count), 32'd1);
        check("rr_pre_fifo_empty", 32'(dut.fifo_empty), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rr_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rr_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        check("rr_wr_count", 32'(wr_count), 32'd0);
        check("rr_cksum", 32'(cksum), 32'd0);
        check("rr_state", 32'(dut.state), 32'(ST_WAIT_LOAD));
        check("rr_hcmd_ready", 32'(hcmd_ready), 32'd1);
        tick();
        reset = 1'b0;
        busy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
